// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit memory that answers processor reads
// after a fixed latency and commits single-cycle writes.
module mem_responder #(
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [15:0] mem_write_addr,
  input  logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_addr,
  output logic [15:0] mem_read_data,
  output logic        mem_read_valid,
  output logic        oob_error
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    VALID   = 2'd2
  } state_t;

  logic [15:0]   storage [DEPTH];

  state_t        state_q, state_d;
  logic [15:0]   cap_addr_q, cap_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          valid_q, valid_d;
  logic          oob_q, oob_d;

  logic          wr_in_range;
  logic          wr_en;
  logic          cap_in_range;
  logic [15:0]   cap_word;
  logic          addr_changed;

  // Range checks use the full 16-bit address; only in-range addresses index storage.
  always_comb begin
    wr_in_range  = ({1'b0, mem_write_addr} < DEPTH_W);
    wr_en        = rst && mem_we && wr_in_range;
    cap_in_range = ({1'b0, cap_addr_q} < DEPTH_W);
    cap_word     = cap_in_range ? storage[cap_addr_q[AW-1:0]] : 16'h0000;
    addr_changed = (mem_read_addr != cap_addr_q);
  end

  // Storage is never cleared by reset; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage[mem_write_addr[AW-1:0]] <= mem_write_data;
    end
  end

  // Read FSM next-state: an address change always restarts the latency count.
  always_comb begin
    state_d    = state_q;
    cap_addr_d = cap_addr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    valid_d    = valid_q;
    oob_d      = mem_we && !wr_in_range;
    case (state_q)
      IDLE: begin
        cap_addr_d = mem_read_addr;
        cnt_d      = CNT_LOAD;
        valid_d    = 1'b0;
        state_d    = PENDING;
      end
      default: begin
        if (addr_changed) begin
          cap_addr_d = mem_read_addr;
          cnt_d      = CNT_LOAD;
          valid_d    = 1'b0;
          state_d    = PENDING;
        end else if (state_q == PENDING) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            rd_data_d = cap_word;
            valid_d   = 1'b1;
            state_d   = VALID;
            if (!cap_in_range) begin
              oob_d = 1'b1;
            end
          end
        end else begin
          rd_data_d = cap_word;
          valid_d   = 1'b1;
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cap_addr_q <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      valid_q    <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_addr_q <= cap_addr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      valid_q    <= valid_d;
      oob_q      <= oob_d;
    end
  end

  assign mem_read_data  = rd_data_q;
  assign mem_read_valid = valid_q;
  assign oob_error      = oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at READ_LATENCY 2 and 1.
module tb_mem_responder;

  logic        clk;
  logic        rst;

  logic        we;
  logic [15:0] waddr, wdata, raddr;
  logic [15:0] rdata;
  logic        rvalid, oob;

  logic        b_we;
  logic [15:0] b_waddr, b_wdata, b_raddr;
  logic [15:0] b_rdata;
  logic        b_rvalid, b_oob;

  int vec_count = 0;
  int err_count = 0;

  mem_responder #(.DEPTH(256), .READ_LATENCY(2)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .mem_we         (we),
    .mem_write_addr (waddr),
    .mem_write_data (wdata),
    .mem_read_addr  (raddr),
    .mem_read_data  (rdata),
    .mem_read_valid (rvalid),
    .oob_error      (oob)
  );

  mem_responder #(.DEPTH(256), .READ_LATENCY(1)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .mem_we         (b_we),
    .mem_write_addr (b_waddr),
    .mem_write_data (b_wdata),
    .mem_read_addr  (b_raddr),
    .mem_read_data  (b_rdata),
    .mem_read_valid (b_rvalid),
    .oob_error      (b_oob)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [15:0] wa, input logic [15:0] wd, input logic [15:0] ra);
    we    = w;
    waddr = wa;
    wdata = wd;
    raddr = ra;
  endtask

  // Advance past one rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkA(input string tag, input logic v, input logic [15:0] d, input logic o);
    checkOutput({tag, ".valid"}, {15'd0, rvalid}, {15'd0, v});
    if (v) checkOutput({tag, ".data"}, rdata, d);
    checkOutput({tag, ".oob"}, {15'd0, oob}, {15'd0, o});
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd0);
    b_we = 1'b0; b_waddr = 16'd0; b_wdata = 16'd0; b_raddr = 16'd0;
    tick();
    tick();
    checkOutput("reset.data",  rdata, 16'h0000);
    checkOutput("reset.valid", {15'd0, rvalid}, 16'd0);
    checkOutput("reset.oob",   {15'd0, oob}, 16'd0);
    checkOutput("reset_b.valid", {15'd0, b_rvalid}, 16'd0);

    rst = 1'b1;
    applyStimulus(1'b1, 16'd5, 16'h1234, 16'd0);
    tick();
    applyStimulus(1'b1, 16'd6, 16'hBEEF, 16'd0);
    tick();

    // Basic read of address 5, latency 2.
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd5);
    tick(); checkA("rd5.e1", 1'b0, 16'h0, 1'b0);
    tick(); checkA("rd5.e2", 1'b0, 16'h0, 1'b0);
    tick(); checkA("rd5.e3", 1'b1, 16'h1234, 1'b0);

    // Address change while pending: 5 never valid, 6 valid after full latency.
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd0);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd5);
    tick(); checkA("chg.cap5", 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd6);
    tick(); checkA("chg.cap6", 1'b0, 16'h0, 1'b0);
    tick(); checkA("chg.e2",   1'b0, 16'h0, 1'b0);
    tick(); checkA("chg.e3",   1'b1, 16'hBEEF, 1'b0);

    // Write to the address being held valid: old word first, new word one edge later.
    applyStimulus(1'b1, 16'd6, 16'h00AA, 16'd6);
    tick(); checkA("rbw.old", 1'b1, 16'hBEEF, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd6);
    tick(); checkA("rbw.new", 1'b1, 16'h00AA, 1'b0);

    // Out-of-range write (low bits alias address 5) pulses oob for one cycle.
    applyStimulus(1'b1, 16'd261, 16'hDEAD, 16'd6);
    tick(); checkA("oobw.pulse", 1'b1, 16'h00AA, 1'b1);
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd6);
    tick(); checkA("oobw.clear", 1'b1, 16'h00AA, 1'b0);

    // Out-of-range read completes with zero data and oob coincident with valid.
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd300);
    tick(); checkA("oobr.e1", 1'b0, 16'h0, 1'b0);
    tick(); checkA("oobr.e2", 1'b0, 16'h0, 1'b0);
    tick(); checkA("oobr.e3", 1'b1, 16'h0000, 1'b1);
    tick(); checkA("oobr.e4", 1'b1, 16'h0000, 1'b0);

    // Write during pending to the captured address is returned by the completing read.
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd7);
    tick(); checkA("wpend.cap", 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, 16'd7, 16'h7777, 16'd7);
    tick(); checkA("wpend.e2", 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd7);
    tick(); checkA("wpend.e3", 1'b1, 16'h7777, 1'b0);

    // Reset mid-pending; a write during reset is ignored and storage survives.
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd5);
    tick(); checkA("rstp.cap", 1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 16'd5, 16'h5555, 16'd5);
    tick();
    checkOutput("rstp.data", rdata, 16'h0000);
    checkA("rstp.in", 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd5);
    tick(); checkA("rstp.e1", 1'b0, 16'h0, 1'b0);
    tick(); checkA("rstp.e2", 1'b0, 16'h0, 1'b0);
    tick(); checkA("rstp.e3", 1'b1, 16'h1234, 1'b0);

    // READ_LATENCY=1 sweep over eight consecutive addresses.
    for (int i = 0; i < 8; i++) begin
      b_we    = 1'b1;
      b_waddr = 16'(16 + i);
      b_wdata = 16'(16'hA000 + i * 16'h0111);
      tick();
    end
    b_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_raddr = 16'(16 + i);
      tick();
      checkOutput($sformatf("sweep%0d.chg", i), {15'd0, b_rvalid}, 16'd0);
      tick();
      checkOutput($sformatf("sweep%0d.valid", i), {15'd0, b_rvalid}, 16'd1);
      checkOutput($sformatf("sweep%0d.data", i), b_rdata, 16'(16'hA000 + i * 16'h0111));
      checkOutput($sformatf("sweep%0d.oob", i), {15'd0, b_oob}, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
